// File: rtl/signed_product_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : signed_product_accumulator_if
//  Description : Term/result bundle for signed_product_accumulator.
//                master drives the term side and observes the result side;
//                slave is the accumulator itself.
//                Term side   : in_valid, in_last, p (signed product)
//                Result side : out_valid, out_sum, out_count, out_sat
//  Revision    : 1.0  initial release
// ============================================================================
interface signed_product_accumulator_if #(
    parameter int WIDTH_P = 29,
    parameter int WIDTH_R = 32,
    parameter int COUNT_W = 8
);
    logic               in_valid;
    logic               in_last;
    logic [WIDTH_P-1:0] p;
    logic               out_valid;
    logic [WIDTH_R-1:0] out_sum;
    logic [COUNT_W-1:0] out_count;
    logic               out_sat;

    modport master (
        output in_valid, in_last, p,
        input  out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_last, p,
        output out_valid, out_sum, out_count, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/signed_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : signed_product_accumulator
//  Description : Accumulates a stream of signed multiplier products into
//                dot-product sums. The term qualifiers are delayed LATENCY
//                cycles to line up with the multiplier output. Each completed
//                sum is presented saturated to WIDTH_R with a term count and
//                a sticky saturation flag.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - slave side of signed_product_accumulator_if
//                       (in_valid, in_last, p -> out_valid, out_sum,
//                        out_count, out_sat)
//  Revision    : 1.0  initial release
// ============================================================================
module signed_product_accumulator #(
    parameter int WIDTH_P   = 29,
    parameter int LATENCY   = 6,
    parameter int WIDTH_ACC = 40,
    parameter int WIDTH_R   = 32,
    parameter int COUNT_W   = 8
) (
    input wire                            clk,
    input wire                            rst,
    signed_product_accumulator_if.slave   bus
);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_ACCUM = 1'b1;

    localparam logic [WIDTH_ACC-1:0] c_ACC_MAX = {1'b0, {(WIDTH_ACC-1){1'b1}}};
    localparam logic [WIDTH_ACC-1:0] c_ACC_MIN = {1'b1, {(WIDTH_ACC-1){1'b0}}};
    localparam logic [WIDTH_R-1:0]   c_R_MAX   = {1'b0, {(WIDTH_R-1){1'b1}}};
    localparam logic [WIDTH_R-1:0]   c_R_MIN   = {1'b1, {(WIDTH_R-1){1'b0}}};
    localparam logic [COUNT_W-1:0]   c_CNT_MAX = {COUNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Qualifier delay line, aligned with the multiplier output p
    // ------------------------------------------------------------------
    logic w_vd;
    logic w_ld;

    generate
        if (LATENCY == 0) begin : g_no_delay
            assign w_vd = bus.in_valid;
            assign w_ld = bus.in_last;
        end else begin : g_delay
            logic [LATENCY-1:0] r_v_pipe;
            logic [LATENCY-1:0] r_l_pipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v_pipe <= '0;
                    r_l_pipe <= '0;
                end else begin
                    r_v_pipe[0] <= bus.in_valid;
                    r_l_pipe[0] <= bus.in_last;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_v_pipe[i] <= r_v_pipe[i-1];
                        r_l_pipe[i] <= r_l_pipe[i-1];
                    end
                end
            end

            assign w_vd = r_v_pipe[LATENCY-1];
            assign w_ld = r_l_pipe[LATENCY-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bubbles (w_vd = 0) hold the state in either case.
    always_comb begin
        w_state_next = r_state;
        if (w_vd) begin
            w_state_next = w_ld ? c_S_IDLE : c_S_ACCUM;
        end
    end

    // ------------------------------------------------------------------
    // Datapath combinational: next accumulator, sticky flag, count, result
    // ------------------------------------------------------------------
    logic [WIDTH_ACC-1:0]     r_acc;
    logic                     r_sat_i;
    logic [COUNT_W-1:0]       r_count;

    logic [WIDTH_ACC-1:0]     w_base;
    logic [COUNT_W-1:0]       w_count_base;
    logic [WIDTH_ACC:0]       w_p_ext;
    logic [WIDTH_ACC:0]       w_sum;
    logic                     w_ovf;
    logic [WIDTH_ACC-1:0]     w_acc_next;
    logic                     w_sat_next;
    logic [COUNT_W-1:0]       w_count_next;
    logic [WIDTH_ACC-WIDTH_R:0] w_upper;
    logic                     w_narrow_ovf;
    logic [WIDTH_R-1:0]       w_sum_r;

    always_comb begin
        // Starting from zero in IDLE restarts the sum, flag and count on the
        // first term without needing an explicit clear on the emit edge.
        w_base       = (r_state == c_S_IDLE) ? '0 : r_acc;
        w_count_base = (r_state == c_S_IDLE) ? '0 : r_count;

        w_p_ext = {{(WIDTH_ACC + 1 - WIDTH_P){bus.p[WIDTH_P-1]}}, bus.p};
        w_sum   = {w_base[WIDTH_ACC-1], w_base} + w_p_ext;

        // Overflow when the extra carry bit disagrees with the sign bit.
        w_ovf = w_sum[WIDTH_ACC] ^ w_sum[WIDTH_ACC-1];
        if (w_ovf) begin
            w_acc_next = w_sum[WIDTH_ACC] ? c_ACC_MIN : c_ACC_MAX;
        end else begin
            w_acc_next = w_sum[WIDTH_ACC-1:0];
        end

        w_sat_next   = w_ovf | ((r_state == c_S_ACCUM) & r_sat_i);
        w_count_next = (w_count_base == c_CNT_MAX) ? w_count_base
                                                   : w_count_base + 1'b1;

        // The value fits WIDTH_R when all bits from the WIDTH_R sign bit
        // upward are identical.
        w_upper      = w_acc_next[WIDTH_ACC-1:WIDTH_R-1];
        w_narrow_ovf = ~((&w_upper) | (~|w_upper));
        if (w_narrow_ovf) begin
            w_sum_r = w_acc_next[WIDTH_ACC-1] ? c_R_MIN : c_R_MAX;
        end else begin
            w_sum_r = w_acc_next[WIDTH_R-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    logic               r_out_valid;
    logic [WIDTH_R-1:0] r_out_sum;
    logic [COUNT_W-1:0] r_out_count;
    logic               r_out_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_sat_i     <= 1'b0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_out_valid <= w_vd & w_ld;
            if (w_vd) begin
                r_acc   <= w_acc_next;
                r_sat_i <= w_sat_next;
                r_count <= w_count_next;
                if (w_ld) begin
                    r_out_sum   <= w_sum_r;
                    r_out_count <= w_count_next;
                    r_out_sat   <= w_sat_next | w_narrow_ovf;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_count = r_out_count;
    assign bus.out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_signed_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_signed_product_accumulator
//  Description : Directed self-checking bench for signed_product_accumulator.
//                A LATENCY-stage multiplier model feeds p; result pulses are
//                captured with their cycle stamp and compared against
//                hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_signed_product_accumulator;

    localparam int WIDTH_P   = 29;
    localparam int LATENCY   = 6;
    localparam int WIDTH_ACC = 40;
    localparam int WIDTH_R   = 32;
    localparam int COUNT_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    signed_product_accumulator_if #(
        .WIDTH_P (WIDTH_P),
        .WIDTH_R (WIDTH_R),
        .COUNT_W (COUNT_W)
    ) bus ();

    signed_product_accumulator #(
        .WIDTH_P   (WIDTH_P),
        .LATENCY   (LATENCY),
        .WIDTH_ACC (WIDTH_ACC),
        .WIDTH_R   (WIDTH_R),
        .COUNT_W   (COUNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Multiplier model: signed product of a and b, LATENCY cycles late.
    logic signed [WIDTH_P-1:0]   a = '0;
    logic signed [WIDTH_P-1:0]   b = '0;
    logic signed [2*WIDTH_P-1:0] prod_full;
    logic [WIDTH_P-1:0]          mul_pipe [LATENCY];

    assign prod_full = a * b;

    always @(posedge clk) begin
        mul_pipe[0] <= prod_full[WIDTH_P-1:0];
        for (int i = 1; i < LATENCY; i++) begin
            mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    assign bus.p = mul_pipe[LATENCY-1];

    // Cycle stamp and result capture
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 stamp;
        logic [WIDTH_R-1:0] sum;
        logic [COUNT_W-1:0] count;
        logic               sat;
    } pulse_t;

    pulse_t pulses[$];

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            pulses.push_back('{cyc, bus.out_sum, bus.out_count, bus.out_sat});
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One term per call; consecutive calls give back-to-back terms.
    task automatic send(input int term, input bit last, output int stamp);
        @(posedge clk);
        #1;
        a            = term[WIDTH_P-1:0];
        b            = 1;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        stamp        = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            a            = '0;
            b            = '0;
        end
    endtask

    task automatic check_pulse(input string tag, input pulse_t pp, input int stamp,
                               input logic [WIDTH_R-1:0] sum, input int count, input bit sat);
        check({tag, "_stamp"}, pp.stamp, stamp);
        check({tag, "_sum"},   pp.sum,   sum);
        check({tag, "_count"}, pp.count, count);
        check({tag, "_sat"},   pp.sat,   sat);
    endtask

    task automatic expect_one(input string tag, input int stamp,
                              input logic [WIDTH_R-1:0] sum, input int count, input bit sat);
        check({tag, "_npulses"}, pulses.size(), 1);
        if (pulses.size() > 0) begin
            check_pulse(tag, pulses[0], stamp, sum, count, sat);
        end
        pulses.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int s1;
        int s2;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", bus.out_valid, 0);
        check("rst_sum",   bus.out_sum,   0);
        check("rst_count", bus.out_count, 0);
        check("rst_sat",   bus.out_sat,   0);

        // 1. Single term -5
        send(-5, 1'b1, s0);
        idle(LATENCY + 4);
        expect_one("single", s0 + 7, 32'hFFFF_FFFB, 1, 1'b0);

        // 2. Dot product 100 - 300 + 50 + 7 = -143 (0xFFFFFF71)
        send(100, 1'b0, s0);
        send(-300, 1'b0, s0);
        send(50, 1'b0, s0);
        send(7, 1'b1, s0);
        idle(LATENCY + 4);
        expect_one("dot", s0 + 7, 32'hFFFF_FF71, 4, 1'b0);

        // 3. Same terms with random bubbles
        send(100, 1'b0, s0);
        idle($urandom_range(3, 0));
        send(-300, 1'b0, s0);
        idle($urandom_range(3, 0));
        send(50, 1'b0, s0);
        idle($urandom_range(3, 0));
        send(7, 1'b1, s0);
        idle(LATENCY + 4);
        expect_one("bubble", s0 + 7, 32'hFFFF_FF71, 4, 1'b0);

        // 4a. 16 * (2^28-1) exceeds 2^31-1: clamp at output narrowing
        for (int i = 0; i < 16; i++) begin
            send((1 << 28) - 1, i == 15, s0);
        end
        idle(LATENCY + 4);
        expect_one("sat_pos", s0 + 7, 32'h7FFF_FFFF, 16, 1'b1);

        // 4b. 9 * -2^28 below -2^31
        for (int i = 0; i < 9; i++) begin
            send(-(1 << 28), i == 8, s0);
        end
        idle(LATENCY + 4);
        expect_one("sat_neg", s0 + 7, 32'h8000_0000, 9, 1'b1);

        // 4c. Sticky flag restarts with the next sum
        send(3, 1'b1, s0);
        idle(LATENCY + 4);
        expect_one("sat_clear", s0 + 7, 32'h0000_0003, 1, 1'b0);

        // 5. Reset with terms in flight
        send(11, 1'b0, s0);
        send(11, 1'b0, s0);
        send(11, 1'b0, s0);
        idle(2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_valid", bus.out_valid, 0);
        check("midrst_sum",   bus.out_sum,   0);
        check("midrst_count", bus.out_count, 0);
        check("midrst_sat",   bus.out_sat,   0);
        send(9, 1'b1, s0);
        idle(6);
        @(negedge clk);
        check("prepulse_valid", bus.out_valid, 0);
        check("prepulse_sum",   bus.out_sum,   0);
        check("prepulse_count", bus.out_count, 0);
        idle(6);
        expect_one("after_rst", s0 + 7, 32'h0000_0009, 1, 1'b0);

        // 6. Back-to-back sums {1, 2} then {10}
        send(1, 1'b0, s1);
        send(2, 1'b1, s1);
        send(10, 1'b1, s2);
        idle(LATENCY + 4);
        check("b2b_npulses", pulses.size(), 2);
        if (pulses.size() >= 2) begin
            check_pulse("b2b_first",  pulses[0], s1 + 7, 32'h0000_0003, 2, 1'b0);
            check_pulse("b2b_second", pulses[1], s2 + 7, 32'h0000_000A, 1, 1'b0);
        end
        pulses.delete();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/signed_product_accumulator.md
# signed_product_accumulator

Downstream consumer of the `lc_mult_signed` pipelined signed multiplier. It accumulates a stream of signed products into dot-product sums and presents each completed sum saturated to the output width, with a term count and a sticky saturation flag. It carries the operand-side `in_valid`/`in_last` qualifiers through an internal delay line matched to the multiplier latency. Upstream logic therefore drives the multiplier operands and this block's qualifiers on the same cycle.

## Interface

Parameters:
- `WIDTH_P`, 29: width of signed product input (multiplier `WIDTH_O`).
- `LATENCY`, 6: multiplier latency in cycles; 0 = combinational multiplier.
- `WIDTH_ACC`, 40: internal accumulator width; must be ≥ `WIDTH_P`.
- `WIDTH_R`, 32: output sum width; must be ≤ `WIDTH_ACC`.
- `COUNT_W`, 8: term counter width.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: term qualifier, driven on the same cycle as the multiplier operands.
- `in_last`, in, 1: final term of the current sum; meaningful only with `in_valid`.
- `p`, in, `WIDTH_P`: signed product from the multiplier, already `LATENCY` cycles late.
- `out_valid`, out, 1: one-cycle pulse; a completed sum is present.
- `out_sum`, out, `WIDTH_R`: signed completed sum, saturated; held between pulses.
- `out_count`, out, `COUNT_W`: number of terms in `out_sum`; saturates at all-ones.
- `out_sat`, out, 1: the sum saturated internally or at output narrowing; held with `out_sum`.

## Operation

- **Delay line.** `LATENCY`-stage shift register of {valid, last}, producing `vd` and `ld`.
  - `vd`/`ld` coincide with `p` for the same term.
  - With `LATENCY`=0, `vd`/`ld` are simply `in_valid`/`in_last`.
- **States.**
  - IDLE: no partial sum.
  - ACCUM: partial sum open.
- **Transitions.** All are taken on an edge where `vd`=1:
  - IDLE and `ld`=0 → ACCUM.
  - IDLE and `ld`=1 → IDLE, emitting a result.
  - ACCUM and `ld`=0 → ACCUM.
  - ACCUM and `ld`=1 → IDLE, emitting a result.
  - Edges where `vd`=0 hold all state; these are bubbles and are ignored in either state.
- **Accumulate.**
  - Form `base` = 0 in IDLE, else `acc`.
  - Form `nxt` = `base` + sign-extended `p`, computed at `WIDTH_ACC`+1 bits.
  - If `nxt` overflows `WIDTH_ACC`, clamp it to signed max/min of `WIDTH_ACC` and set sticky `sat_i`.
  - `sat_i` and the term count restart with the first term of each sum.
- **Emit.** On the `ld` edge:
  - `out_sum` = `nxt` clamped to the `WIDTH_R` signed range.
  - `out_sat` = `sat_i` (including this term) OR the narrowing clamp.
  - `out_count` = terms including this one.
  - `out_valid` = 1.
  - `acc` is then don't-care; the next term starts from 0 because the state is IDLE.
- **Back-to-back sums.** A term with `vd`=1 on the edge immediately after an `ld` edge starts a new sum with no gap.
- **Reset.**
  - Clears the delay line, so in-flight terms are dropped.
  - Also clears `acc`, `sat_i`, the count, and the state (→ IDLE).
  - Output reset values: `out_valid`=0, `out_sum`=0, `out_count`=0, `out_sat`=0.
  - `rst` overrides every other input on the same edge.
- **No backpressure.** Downstream must accept every `out_valid` pulse.

## Timing

- `in_valid`&`in_last` sampled at edge k → `out_valid`=1 during the cycle after edge k+`LATENCY`.
- `out_valid` is high for exactly one cycle per completed sum.
- Maximum throughput is one sum per cycle (single-term sums).
- All outputs are registered; there is no combinational path from inputs to outputs.
- The carry chain is `WIDTH_ACC`+1 bits, with a single register stage per term.
- After `rst` deasserts, the first result needs a full `LATENCY`+1 cycles.

## Test plan

Default parameters; the multiplier model is the reference signed product delayed 6 cycles.

1. **Single term.** a=-5, b=1, `in_last`=1 → exactly 7 cycles later:
   - `out_valid` pulse
   - `out_sum`=0xFFFFFFFB, `out_count`=1, `out_sat`=0
2. **Dot product.** Terms 100, -300, 50, 7 on consecutive cycles, last on 7 → `out_sum`=-143, `out_count`=4, `out_sat`=0; one pulse only.
3. **Bubbles.** Same four terms with 0–3 random idle cycles between them → identical result; pulse 7 cycles after the `in_last` cycle.
4. **Saturation.**
   - 16 terms of 2^28-1 → `out_sum`=0x7FFFFFFF, `out_sat`=1, `out_count`=16.
   - 9 terms of -2^28 → `out_sum`=0x80000000, `out_sat`=1.
   - A following 1-term sum of 3 → `out_sat`=0.
5. **Reset mid-flight.** Issue 3 terms without last, then `rst` for 1 cycle 2 cycles later, then a 1-term sum of 9:
   - only one `out_valid`, with `out_sum`=9, `out_count`=1
   - all outputs are 0 during and after reset until that pulse
6. **Back-to-back.** Sums {1, 2(last)} then {10(last)} on consecutive cycles → pulses on consecutive cycles: (3, count 2), then (10, count 1).
